// File: rtl/fp_mul_arbiter_pkg.sv
// Shared types and constants for the Q1.15 multiplier arbiter.
// Q1.15 operands, Q2.30 full product, and the Q1.15 range limits.
package FpArbPkg;
  typedef logic signed [15:0] q1_15_t;
  typedef logic signed [31:0] q2_30_t;

  localparam int     Q15_FRAC = 15;
  localparam q1_15_t Q15_MAX  = 16'h7FFF;
  localparam q1_15_t Q15_MIN  = 16'h8000;
endpackage

// File: rtl/fp_mul_arbiter_rr.sv
// Round-robin arbiter: searches upward from ptr, ptr moves past winner.
// Grants only while en is high; ptr holds when nothing is granted.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id
);
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;
  logic            hit;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    hit    = 1'b0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % N_REQ);
      if (!hit && en && req[idx]) begin
        hit      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (hit) begin
      if (int'(gnt_id) == N_REQ - 1)
        ptr <= '0;
      else
        ptr <= gnt_id + 1'b1;
    end
  end
endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one 2-stage Q1.15 multiplier among N_REQ requesters, round-robin.
// FP_MUL_ARB_SAT_EN: saturate 0x8000*0x8000 to 0x7FFF instead of wrapping.
module fp_mul_arbiter
  import FpArbPkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*16-1:0] req_a,
  input  logic [N_REQ*16-1:0] req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [15:0]         rsp_data
);
  logic             stall;
  logic             take;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;

  q1_15_t          op_a, op_b;
  q1_15_t          s1_a, s1_b;
  logic [ID_W-1:0] s1_id;
  logic            s1_valid;
  logic            s2_valid;

  q2_30_t prod;
  q2_30_t shr;
  q1_15_t res;
  logic   unused_hi;

  assign stall     = s2_valid & ~rsp_ready;
  assign rsp_valid = s2_valid;
  assign req_ready = gnt;
  assign take      = |gnt;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .en     (~stall & ~rst),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign op_a = req_a[int'(gnt_id)*16 +: 16];
  assign op_b = req_b[int'(gnt_id)*16 +: 16];

  // Arithmetic shift floors toward -inf; the high bits only matter for -1*-1.
  assign prod      = q2_30_t'(s1_a) * q2_30_t'(s1_b);
  assign shr       = prod >>> Q15_FRAC;
  assign unused_hi = ^shr[31:16];

`ifdef FP_MUL_ARB_SAT_EN
  assign res = (s1_a == Q15_MIN && s1_b == Q15_MIN) ? Q15_MAX : shr[15:0];
`else
  assign res = shr[15:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else if (!stall) begin
      s1_valid <= take;
      if (take) begin
        s1_a  <= op_a;
        s1_b  <= op_b;
        s1_id <= gnt_id;
      end
      s2_valid <= s1_valid;
      rsp_id   <= s1_id;
      rsp_data <= res;
    end
  end
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Randomised bench for fp_mul_arbiter against a queue-based reference model.
// Build with FP_MUL_ARB_SAT_EN defined to expect saturation of -1*-1.
module tb_fp_mul_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*16-1:0] req_a;
  logic [N*16-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [15:0]    rsp_data;

  int checks   = 0;
  int failures = 0;

  logic        va [N];
  logic [15:0] aa [N];
  logic [15:0] bb [N];

  int          qid  [$];
  logic [15:0] qd   [$];
  int          qage [$];
  int          mptr = 0;
  int          last_gnt = -1;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Real-valued product floored to the Q1.15 grid.
  function automatic logic [15:0] ref_mul(input logic [15:0] a,
                                          input logic [15:0] b);
    real r;
    int  f;
    r = $itor($signed(a)) * $itor($signed(b)) / 32768.0;
    f = $rtoi($floor(r));
    if (f > 32767) begin
`ifdef FP_MUL_ARB_SAT_EN
      f = 32767;
`else
      f = -32768;
`endif
    end
    return f[15:0];
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0001;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = va[i];
      req_a[i*16 +: 16] = aa[i];
      req_b[i*16 +: 16] = bb[i];
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle(input logic rr);
    logic         ev, es;
    logic [N-1:0] eg;
    int           g;
    rsp_ready = rr;
    drive();
    @(negedge clk);
    ev = (qid.size() > 0) && (qage[0] >= 1);
    es = ev && !rr;
    g  = -1;
    eg = '0;
    if (!es) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (mptr + k) % N;
        if (g < 0 && va[j]) g = j;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(eg));
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev) begin
      check("rsp_id", 32'(rsp_id), qid[0]);
      check("rsp_data", 32'(rsp_data), 32'(qd[0]));
    end
    last_gnt = g;
    @(posedge clk);
    #1;
    if (ev && rr) begin
      void'(qid.pop_front());
      void'(qd.pop_front());
      void'(qage.pop_front());
    end
    if (!es) foreach (qage[k]) qage[k]++;
    if (g >= 0) begin
      qid.push_back(g);
      qd.push_back(ref_mul(aa[g], bb[g]));
      qage.push_back(0);
      mptr  = (g + 1) % N;
      va[g] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    rsp_ready = 1'b1;
    drive();
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    qid.delete();
    qd.delete();
    qage.delete();
    mptr = 0;
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
  endtask

  logic [15:0] ta [8] = '{16'h4000, 16'hC000, 16'h0001, 16'h8000,
                          16'h7FFF, 16'h8000, 16'hFFFF, 16'h8000};
  logic [15:0] tb [8] = '{16'h4000, 16'h4000, 16'hFFFF, 16'h8000,
                          16'h7FFF, 16'h7FFF, 16'hFFFF, 16'h0001};
`ifdef FP_MUL_ARB_SAT_EN
  logic [15:0] te [8] = '{16'h2000, 16'hE000, 16'hFFFF, 16'h7FFF,
                          16'h7FFE, 16'h8001, 16'h0000, 16'hFFFF};
`else
  logic [15:0] te [8] = '{16'h2000, 16'hE000, 16'hFFFF, 16'h8000,
                          16'h7FFE, 16'h8001, 16'h0000, 16'hFFFF};
`endif

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      va[i] = 1'b0;
      aa[i] = '0;
      bb[i] = '0;
    end
    drive();
    @(posedge clk);
    #1;
    do_reset();

    // single request from requester 2
    va[2] = 1'b1; aa[2] = 16'h4000; bb[2] = 16'h4000;
    cycle(1'b1);
    check("single_gnt", last_gnt, 2);
    cycle(1'b1);
    check("single_valid", 32'(rsp_valid), 32'h1);
    check("single_id", 32'(rsp_id), 32'h2);
    check("single_data", 32'(rsp_data), 32'h2000);
    cycle(1'b1);

    // directed arithmetic corners
    for (int i = 0; i < 8; i++) begin
      va[0] = 1'b1; aa[0] = ta[i]; bb[0] = tb[i];
      cycle(1'b1);
      cycle(1'b1);
      check("arith_data", 32'(rsp_data), 32'(te[i]));
      cycle(1'b1);
    end

    // fairness with everyone continuously valid
    do_reset();
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!va[i]) begin
          va[i] = 1'b1; aa[i] = pick(); bb[i] = pick();
        end
      end
      cycle(1'b1);
      check("fair_gnt", last_gnt, k % N);
    end
    for (int i = 0; i < N; i++) va[i] = 1'b0;
    cycle(1'b1);
    cycle(1'b1);
    check("fair_drain", qid.size(), 0);

    // backpressure with two products in flight
    do_reset();
    va[0] = 1'b1; aa[0] = 16'h2000; bb[0] = 16'h4000;
    cycle(1'b1);
    va[1] = 1'b1; aa[1] = 16'hC000; bb[1] = 16'h7FFF;
    cycle(1'b1);
    va[2] = 1'b1; aa[2] = 16'h1234; bb[2] = 16'hF00D;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0);
      check("bp_held_q", qid.size(), 2);
    end
    for (int k = 0; k < 4; k++) cycle(1'b1);
    check("bp_drain", qid.size(), 0);

    // reset with S1 and S2 both occupied
    va[0] = 1'b1; aa[0] = 16'h7000; bb[0] = 16'h7000;
    cycle(1'b1);
    va[1] = 1'b1; aa[1] = 16'h9000; bb[1] = 16'h3000;
    cycle(1'b1);
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b1);
    for (int i = 0; i < N; i++) begin
      va[i] = 1'b1; aa[i] = pick(); bb[i] = pick();
    end
    drive();
    #1;
    check("ptr_zero", 32'(req_ready), 32'h1);

    // randomised traffic with random backpressure and occasional reset
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!va[i] && $urandom_range(0, 1) == 1) begin
          va[i] = 1'b1; aa[i] = pick(); bb[i] = pick();
        end
      end
      if (n % 200 == 199) do_reset();
      else cycle($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < N; i++) va[i] = 1'b0;
    for (int k = 0; k < 4; k++) cycle(1'b1);
    check("final_drain", qid.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
